// File: rtl/rob_if.sv
// Decoder / writeback / regfile / commit bus of the reorder buffer.
interface rob_if #(parameter int ROB_BIT = 3);
  logic               issue_valid;
  logic [1:0]         issue_type;
  logic [4:0]         issue_rd;
  logic [31:0]        issue_pc;
  logic               issue_pred_taken;
  logic               issue_ready;
  logic [31:0]        issue_value;
  logic               rob_full;
  logic [ROB_BIT-1:0] issue_rob_entry;

  logic               wb_valid;
  logic [ROB_BIT-1:0] wb_rob_entry;
  logic [31:0]        wb_value;
  logic               wb_taken;
  logic [31:0]        wb_target;

  logic [ROB_BIT-1:0] get_rob_entry1, get_rob_entry2;
  logic               ready1, ready2;
  logic [31:0]        value1, value2;

  logic               rob_commit;
  logic [4:0]         commit_reg_id;
  logic [31:0]        commit_reg_data;
  logic [ROB_BIT-1:0] commit_rob_entry;
  logic               commit_store;
  logic               rob_clear_up;
  logic [31:0]        clear_pc;
  logic               debug_rob_empty;

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken, issue_ready, issue_value,
    input  wb_valid, wb_rob_entry, wb_value, wb_taken, wb_target,
    input  get_rob_entry1, get_rob_entry2,
    output rob_full, issue_rob_entry, ready1, ready2, value1, value2,
    output rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry, commit_store,
    output rob_clear_up, clear_pc, debug_rob_empty
  );

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pc, issue_pred_taken, issue_ready, issue_value,
    output wb_valid, wb_rob_entry, wb_value, wb_taken, wb_target,
    output get_rob_entry1, get_rob_entry2,
    input  rob_full, issue_rob_entry, ready1, ready2, value1, value2,
    input  rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry, commit_store,
    input  rob_clear_up, clear_pc, debug_rob_empty
  );
endinterface

// File: rtl/rob_buffer.sv
// Circular reorder buffer: in-order issue, out-of-order writeback with operand bypass,
// in-order registered commit, and full flush on a mispredicted branch.
module rob_entry (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        en,
  input  logic        clr,
  input  logic        alloc,
  input  logic [1:0]  a_type,
  input  logic [4:0]  a_rd,
  input  logic        a_pred,
  input  logic        a_ready,
  input  logic [31:0] a_value,
  input  logic        wb,
  input  logic [31:0] wb_value,
  input  logic        wb_taken,
  input  logic [31:0] wb_target,
  input  logic        retire,
  output logic        busy,
  output logic        ready,
  output logic [1:0]  etype,
  output logic [4:0]  rd,
  output logic        pred,
  output logic [31:0] value,
  output logic        taken,
  output logic [31:0] target
);
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy <= 1'b0; ready <= 1'b0; etype <= '0; rd <= '0; pred <= 1'b0;
      value <= '0; taken <= 1'b0; target <= '0;
    end else if (en) begin
      if (clr) begin
        busy  <= 1'b0;
        ready <= 1'b0;
      end else if (alloc) begin
        busy <= 1'b1; ready <= a_ready; etype <= a_type; rd <= a_rd; pred <= a_pred;
        value <= a_value; taken <= 1'b0; target <= '0;
      end else begin
        if (wb && busy) begin
          value <= wb_value; taken <= wb_taken; target <= wb_target; ready <= 1'b1;
        end
        // Retiring frees the slot; a late writeback to it is dropped.
        if (retire) begin
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      end
    end
  end
endmodule

module rob_buffer #(parameter int ROB_BIT = 3) (
  input logic  clk_in,
  input logic  rst_in,
  input logic  rdy_in,
  rob_if.slave bus
);
  localparam int DEPTH = 1 << ROB_BIT;
  localparam int CW    = ROB_BIT + 1;

  logic [ROB_BIT-1:0] head, tail;
  logic [CW-1:0]      count;
  logic               full, clear_q;
  logic               issue_acc, commit_go, mispredict, commit_fire, wb_ok;
  logic               hit1, hit2;

  logic [DEPTH-1:0]         busy_v, rdy_v, pred_v, taken_v, alloc_v, wb_v, retire_v;
  logic [DEPTH-1:0][1:0]    type_v;
  logic [DEPTH-1:0][4:0]    rd_v;
  logic [DEPTH-1:0][31:0]   value_v, target_v;

  // The PC rides along with the decoder's bookkeeping; no entry field needs it.
  logic unused_pc;
  assign unused_pc = ^bus.issue_pc;

  assign full                = (count == CW'(DEPTH));
  assign bus.rob_full        = full;
  assign bus.debug_rob_empty = (count == '0);
  assign bus.issue_rob_entry = tail;
  assign bus.rob_clear_up    = clear_q;

  assign issue_acc   = bus.issue_valid && !full && !clear_q;
  assign wb_ok       = bus.wb_valid && !clear_q;
  assign commit_go   = busy_v[head] && rdy_v[head] && !clear_q;
  assign mispredict  = commit_go && (type_v[head] == 2'd2) && (taken_v[head] != pred_v[head]);
  assign commit_fire = commit_go && !mispredict;

  assign hit1       = bus.wb_valid && (bus.wb_rob_entry == bus.get_rob_entry1);
  assign hit2       = bus.wb_valid && (bus.wb_rob_entry == bus.get_rob_entry2);
  assign bus.ready1 = hit1 || (busy_v[bus.get_rob_entry1] && rdy_v[bus.get_rob_entry1]);
  assign bus.ready2 = hit2 || (busy_v[bus.get_rob_entry2] && rdy_v[bus.get_rob_entry2]);
  assign bus.value1 = hit1 ? bus.wb_value : value_v[bus.get_rob_entry1];
  assign bus.value2 = hit2 ? bus.wb_value : value_v[bus.get_rob_entry2];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign alloc_v[i]  = issue_acc   && (tail == ROB_BIT'(i));
    assign wb_v[i]     = wb_ok       && (bus.wb_rob_entry == ROB_BIT'(i));
    assign retire_v[i] = commit_fire && (head == ROB_BIT'(i));

    rob_entry u_ent (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .en       (rdy_in),
      .clr      (clear_q),
      .alloc    (alloc_v[i]),
      .a_type   (bus.issue_type),
      .a_rd     (bus.issue_rd),
      .a_pred   (bus.issue_pred_taken),
      .a_ready  (bus.issue_ready),
      .a_value  (bus.issue_value),
      .wb       (wb_v[i]),
      .wb_value (bus.wb_value),
      .wb_taken (bus.wb_taken),
      .wb_target(bus.wb_target),
      .retire   (retire_v[i]),
      .busy     (busy_v[i]),
      .ready    (rdy_v[i]),
      .etype    (type_v[i]),
      .rd       (rd_v[i]),
      .pred     (pred_v[i]),
      .value    (value_v[i]),
      .taken    (taken_v[i]),
      .target   (target_v[i])
    );
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      head <= '0; tail <= '0; count <= '0; clear_q <= 1'b0;
      bus.rob_commit <= 1'b0; bus.commit_reg_id <= '0; bus.commit_reg_data <= '0;
      bus.commit_rob_entry <= '0; bus.commit_store <= 1'b0; bus.clear_pc <= '0;
    end else if (rdy_in) begin
      bus.rob_commit <= 1'b0;
      clear_q        <= 1'b0;
      if (clear_q) begin
        head <= '0; tail <= '0; count <= '0;
      end else begin
        if (issue_acc)   tail <= tail + 1'b1;
        if (commit_fire) head <= head + 1'b1;
        case ({issue_acc, commit_fire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        // Head stays put on a mispredict; the whole buffer is wiped next cycle anyway.
        if (mispredict) begin
          clear_q           <= 1'b1;
          bus.clear_pc      <= target_v[head];
          bus.commit_reg_id <= '0;
          bus.commit_store  <= 1'b0;
        end else if (commit_fire) begin
          bus.rob_commit       <= 1'b1;
          bus.commit_rob_entry <= head;
          bus.commit_reg_data  <= value_v[head];
          bus.commit_reg_id    <= (type_v[head] == 2'd0) ? rd_v[head] : 5'd0;
          bus.commit_store     <= (type_v[head] == 2'd1);
        end
      end
    end
  end
endmodule
